// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared sizes and FSM/owner encodings for the instruction ROM arbiter
package rom_arbiter_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ROM_DEPTH  = 64;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;
    typedef enum logic {
        ARB_OWNER_F = 1'b0,
        ARB_OWNER_D = 1'b1
    } arb_owner_e;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: fetch/debug requester handshakes plus the ROM address/data pair
interface rom_arbiter_if
    import rom_arbiter_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = $clog2(ROM_DEPTH)
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_data,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, rom_addr, busy
    );
    modport master (
        output f_req, f_addr, d_req, d_addr, rom_data,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way arbiter; ARB_RR_EN selects round-robin ties, else fetch priority
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       req_f,
    input  logic       req_d,
    input  arb_owner_e last,
    output arb_owner_e win
);
    arb_owner_e tie;
`ifdef ARB_RR_EN
    // on a tie the requester that was not served last wins
    always_comb tie = (last == ARB_OWNER_D) ? ARB_OWNER_F : ARB_OWNER_D;
`else
    logic unused_last;
    assign unused_last = last;
    // fixed priority: fetch always wins a tie
    always_comb tie = ARB_OWNER_F;
`endif
    // single requester wins outright; the idle case is a don't-care
    always_comb win = (req_f && req_d) ? tie : ((req_f || !req_d) ? ARB_OWNER_F : ARB_OWNER_D);
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between fetch and debug; tie policy set by ARB_RR_EN
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int DW    = DATA_WIDTH,
    parameter int DEPTH = ROM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic          clk,
    input logic          rstn,
    rom_arbiter_if.slave bus
);
    arb_state_e    state_q;
    arb_owner_e    owner_q;
    arb_owner_e    last_q;
    arb_owner_e    win;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          f_gnt_q;
    logic          d_gnt_q;
    logic          f_rvalid_q;
    logic          d_rvalid_q;
    logic          arb;

    rr_arb2 u_arb (
        .req_f (bus.f_req),
        .req_d (bus.d_req),
        .last  (last_q),
        .win   (win)
    );

    // requests are only sampled outside ADDR, so at most one access is in flight
    assign arb = (state_q != ARB_ADDR) && (bus.f_req || bus.d_req);

    // FSM, address/data capture and registered handshake pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_IDLE;
            owner_q    <= ARB_OWNER_F;
            last_q     <= ARB_OWNER_D;
            addr_q     <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= arb ? ARB_ADDR : ((state_q == ARB_ADDR) ? ARB_RESP : ARB_IDLE);
            f_gnt_q    <= arb && (win == ARB_OWNER_F);
            d_gnt_q    <= arb && (win == ARB_OWNER_D);
            f_rvalid_q <= (state_q == ARB_ADDR) && (owner_q == ARB_OWNER_F);
            d_rvalid_q <= (state_q == ARB_ADDR) && (owner_q == ARB_OWNER_D);
            if (arb) begin
                owner_q <= win;
                addr_q  <= (win == ARB_OWNER_D) ? bus.d_addr : bus.f_addr;
            end
            if (state_q == ARB_ADDR) begin
                last_q <= owner_q;
                if (owner_q == ARB_OWNER_F) f_rdata_q <= bus.rom_data;
                else d_rdata_q <= bus.rom_data;
            end
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.f_gnt    = f_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.f_rvalid = f_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state_q != ARB_IDLE);
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of rom_arbiter against a ROM holding word[i] = 32'h1000_0000 + i
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic exp_f;

    rom_arbiter_if bus ();
    rom_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;
    assign bus.rom_data = 32'h1000_0000 + 32'(bus.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        bus.f_addr = '0;
        bus.d_addr = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_hs", 32'({bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid}), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_rdata", bus.f_rdata | bus.d_rdata, 0);
        rstn = 1'b1;
        tick();
        // single fetch
        bus.f_req = 1'b1;
        bus.f_addr = 6'd5;
        chk("t1_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("t1_f_gnt", 32'(bus.f_gnt), 1);
        chk("t1_d_gnt", 32'(bus.d_gnt), 0);
        chk("t1_rom_addr", 32'(bus.rom_addr), 5);
        chk("t1_busy", 32'(bus.busy), 1);
        bus.f_req = 1'b0;
        tick();
        chk("t1_f_rvalid", 32'(bus.f_rvalid), 1);
        chk("t1_f_rdata", bus.f_rdata, 32'h1000_0005);
        chk("t1_f_gnt_off", 32'(bus.f_gnt), 0);
        tick();
        chk("t1_idle", 32'(bus.busy), 0);
        chk("t1_rvalid_off", 32'(bus.f_rvalid), 0);
        // tie straight after reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        bus.f_req = 1'b1;
        bus.f_addr = 6'd1;
        bus.d_req = 1'b1;
        bus.d_addr = 6'd2;
        tick();
        chk("t2_f_gnt", 32'(bus.f_gnt), 1);
        chk("t2_d_gnt_c1", 32'(bus.d_gnt), 0);
        bus.f_req = 1'b0;
        tick();
        chk("t2_f_rvalid", 32'(bus.f_rvalid), 1);
        chk("t2_f_rdata", bus.f_rdata, 32'h1000_0001);
        chk("t2_d_gnt_c2", 32'(bus.d_gnt), 0);
        tick();
        chk("t2_d_gnt", 32'(bus.d_gnt), 1);
        chk("t2_rom_addr", 32'(bus.rom_addr), 2);
        bus.d_req = 1'b0;
        tick();
        chk("t2_d_rvalid", 32'(bus.d_rvalid), 1);
        chk("t2_d_rdata", bus.d_rdata, 32'h1000_0002);
        chk("t2_f_rvalid_off", 32'(bus.f_rvalid), 0);
        chk("t2_f_rdata_hold", bus.f_rdata, 32'h1000_0001);
        tick();
        chk("t2_idle", 32'(bus.busy), 0);
        // both requesters held high: alternate under round-robin, fetch only under priority
        bus.f_addr = 6'd7;
        bus.d_addr = 6'd9;
        bus.f_req = 1'b1;
        bus.d_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_f = RR ? (k % 2 == 0) : 1'b1;
            tick();
            chk($sformatf("t3_f_gnt_%0d", k), 32'(bus.f_gnt), 32'(exp_f));
            chk($sformatf("t3_d_gnt_%0d", k), 32'(bus.d_gnt), 32'(!exp_f));
            tick();
            chk($sformatf("t3_rvalid_%0d", k), 32'({bus.f_rvalid, bus.d_rvalid}), exp_f ? 2 : 1);
            chk($sformatf("t3_rdata_%0d", k), exp_f ? bus.f_rdata : bus.d_rdata,
                exp_f ? 32'h1000_0007 : 32'h1000_0009);
            if (k == 7) begin
                bus.f_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        tick();
        chk("t3_idle", 32'(bus.busy), 0);
        // back-to-back fetches reissued in each response cycle
        for (int a = 3; a < 6; a++) begin
            bus.f_req = 1'b1;
            bus.f_addr = 6'(a);
            tick();
            chk($sformatf("t4_f_gnt_%0d", a), 32'(bus.f_gnt), 1);
            chk($sformatf("t4_rom_addr_%0d", a), 32'(bus.rom_addr), 32'(a));
            tick();
            chk($sformatf("t4_f_rvalid_%0d", a), 32'(bus.f_rvalid), 1);
            chk($sformatf("t4_f_rdata_%0d", a), bus.f_rdata, 32'h1000_0000 + 32'(a));
            chk($sformatf("t4_busy_%0d", a), 32'(bus.busy), 1);
        end
        bus.f_req = 1'b0;
        tick();
        chk("t4_idle", 32'(bus.busy), 0);
        // reset asserted while in ADDR
        bus.f_req = 1'b1;
        bus.f_addr = 6'd6;
        tick();
        chk("t5_f_gnt", 32'(bus.f_gnt), 1);
        rstn = 1'b0;
        #1;
        chk("t5_gnt_cleared", 32'(bus.f_gnt), 0);
        chk("t5_busy_cleared", 32'(bus.busy), 0);
        chk("t5_rom_addr_cleared", 32'(bus.rom_addr), 0);
        bus.f_req = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("t5_no_rvalid_a", 32'({bus.f_rvalid, bus.busy}), 0);
        tick();
        chk("t5_no_rvalid_b", 32'({bus.f_rvalid, bus.busy}), 0);
        // idle period keeps outputs quiet and rom_addr on the last address
        bus.f_req = 1'b1;
        bus.f_addr = 6'd11;
        tick();
        bus.f_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t6_quiet_%0d", i),
                32'({bus.busy, bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid}), 0);
            tick();
        end
        chk("t6_rom_addr_hold", 32'(bus.rom_addr), 11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
